// File: rtl/coin_window_if.sv
// Bundle of window-control inputs and result outputs for coin_window_counter.
// The master side drives the coincidence level and window commands; the slave side reports results.
interface coin_window_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 10
);
    logic             coin;
    logic             start;
    logic             abort;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] thresh;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] count;
    logic             alarm;
    logic             ovf;

    modport master (
        output coin, start, abort, win_len, thresh,
        input  busy, done, count, alarm, ovf
    );

    modport slave (
        input  coin, start, abort, win_len, thresh,
        output busy, done, count, alarm, ovf
    );
endinterface

// File: rtl/coin_window_counter.sv
// Synchronises the raw coincidence level, detects rising edges and counts them
// inside a programmable window, reporting count, threshold alarm and saturation.
module coin_window_counter #(
    parameter int CNT_W       = 8,
    parameter int WIN_W       = 10,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    coin_window_if.slave       bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

    // A zero window length still yields one RUN cycle.
    function automatic logic [WIN_W-1:0] win_load(input logic [WIN_W-1:0] w);
        return (w == '0) ? WIN_W'(1) : w;
    endfunction

    logic [SYNC_STAGES-1:0] coin_sync_p0;
    logic                   coin_prev_p1;
    logic                   coin_edge;

    logic [1:0]       state;
    logic [WIN_W-1:0] timer;
    logic [CNT_W-1:0] thresh_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_run;
    logic             ovf_hit;
    logic             ovf_q;
    logic             alarm_q;
    logic             busy_q;
    logic             done_q;

    // Stage p0/p1: synchroniser chain and previous-level flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coin_sync_p0 <= '0;
            coin_prev_p1 <= 1'b0;
        end else begin
            coin_sync_p0 <= {coin_sync_p0[SYNC_STAGES-2:0], bus.coin};
            coin_prev_p1 <= coin_sync_p0[SYNC_STAGES-1];
        end
    end

    assign coin_edge = coin_sync_p0[SYNC_STAGES-1] & ~coin_prev_p1;
    assign count_run = coin_edge ? sat_inc(count_q) : count_q;
    assign ovf_hit   = coin_edge && (count_q == CNT_MAX);

    // Window control: edges outside RUN fall through without effect
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            timer    <= '0;
            thresh_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            alarm_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        state    <= ST_RUN;
                        busy_q   <= 1'b1;
                        count_q  <= '0;
                        ovf_q    <= 1'b0;
                        alarm_q  <= 1'b0;
                        timer    <= win_load(bus.win_len);
                        thresh_q <= bus.thresh;
                    end
                end
                ST_RUN: begin
                    if (bus.abort) begin
                        state   <= ST_IDLE;
                        busy_q  <= 1'b0;
                        alarm_q <= 1'b0;
                    end else begin
                        count_q <= count_run;
                        if (ovf_hit) ovf_q <= 1'b1;
                        timer <= timer - WIN_W'(1);
                        if (timer == WIN_W'(1)) begin
                            state   <= ST_FIN;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            alarm_q <= (count_run >= thresh_q);
                        end
                    end
                end
                ST_FIN: begin
                    state  <= ST_IDLE;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.alarm = alarm_q;
    assign bus.ovf   = ovf_q;

endmodule

// File: tb/tb_coin_window_counter.sv
// Randomised and directed bench for coin_window_counter against a cycle-level
// reference model built from the window rules with plain integer arithmetic.
module tb_coin_window_counter;

    localparam int CNT_W       = 8;
    localparam int WIN_W       = 10;
    localparam int SYNC_STAGES = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    coin_window_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    coin_window_counter #(
        .CNT_W(CNT_W),
        .WIN_W(WIN_W),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: raw (unbounded) edge count, remaining RUN cycles, FIN flag
    int m_cnt, m_left, m_thr;
    bit m_fin, m_busy, m_done, m_alarm;
    bit hist [0:SYNC_STAGES];
    int cyc_n = 0;
    int done_cnt = 0;
    int last_done = -1;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    function automatic int m_count();
        return (m_cnt > CNT_MAX) ? CNT_MAX : m_cnt;
    endfunction

    task automatic model_reset();
        m_cnt = 0; m_left = 0; m_thr = 0;
        m_fin = 0; m_busy = 0; m_done = 0; m_alarm = 0;
        for (int i = 0; i <= SYNC_STAGES; i++) hist[i] = 0;
    endtask

    task automatic model_step();
        bit e;
        if (!rst_n) begin
            model_reset();
            return;
        end
        // COIN sampled SYNC_STAGES edges ago, rising relative to the sample before it
        e = hist[SYNC_STAGES-1] & ~hist[SYNC_STAGES];
        for (int i = SYNC_STAGES; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = bus.coin;
        if (m_left > 0) begin
            if (bus.abort) begin
                m_left = 0; m_busy = 0; m_alarm = 0;
            end else begin
                if (e) m_cnt++;
                m_left--;
                if (m_left == 0) begin
                    m_fin = 1; m_busy = 0; m_done = 1;
                    m_alarm = (m_count() >= m_thr);
                end
            end
        end else if (m_fin) begin
            m_fin = 0; m_done = 0;
        end else if (bus.start && !bus.abort) begin
            m_cnt = 0; m_alarm = 0; m_busy = 1;
            m_left = (bus.win_len == 0) ? 1 : int'(bus.win_len);
            m_thr = int'(bus.thresh);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        cyc_n++;
        #1;
        check_val("busy",  bus.busy,  m_busy);
        check_val("done",  bus.done,  m_done);
        check_val("count", bus.count, m_count());
        check_val("alarm", bus.alarm, m_alarm);
        check_val("ovf",   bus.ovf,   (m_cnt > CNT_MAX));
        if (bus.done === 1'b1) begin
            done_cnt++;
            last_done = cyc_n;
        end
    endtask

    task automatic async_reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_val({tag, "_busy"},  bus.busy,  0);
        check_val({tag, "_done"},  bus.done,  0);
        check_val({tag, "_count"}, bus.count, 0);
        check_val({tag, "_alarm"}, bus.alarm, 0);
        check_val({tag, "_ovf"},   bus.ovf,   0);
    endtask

    int t, d0;

    initial begin
        bus.coin = 0; bus.start = 0; bus.abort = 0; bus.win_len = '0; bus.thresh = '0;
        model_reset();
        repeat (2) cyc();
        check_val("rst_state_count", bus.count, 0);
        check_val("rst_state_busy",  bus.busy,  0);
        rst_n = 1'b1;
        repeat (2) cyc();

        // Basic window with three pulses
        bus.win_len = WIN_W'(10); bus.thresh = CNT_W'(3);
        bus.start = 1; bus.coin = 1; t = cyc_n; d0 = done_cnt;
        cyc();
        bus.start = 0;
        for (int k = 1; k < 16; k++) begin
            bus.coin = ((k % 4) < 2) && (k < 10);
            cyc();
        end
        check_val("t1_done_at", last_done - t, 11);
        check_val("t1_done_n",  done_cnt - d0, 1);
        check_val("t1_count",   bus.count, 3);
        check_val("t1_alarm",   bus.alarm, 1);
        check_val("t1_ovf",     bus.ovf,   0);

        // Level held high; an earlier pulse in IDLE is discarded
        bus.coin = 1; repeat (2) cyc();
        bus.coin = 0; repeat (4) cyc();
        bus.win_len = WIN_W'(20); bus.thresh = CNT_W'(2);
        bus.start = 1; bus.coin = 1; t = cyc_n;
        cyc();
        bus.start = 0;
        repeat (22) cyc();
        check_val("t2_count",   bus.count, 1);
        check_val("t2_alarm",   bus.alarm, 0);
        check_val("t2_done_at", last_done - t, 21);
        bus.coin = 0; repeat (4) cyc();

        // Saturation and clear on next start
        bus.win_len = WIN_W'(1023); bus.thresh = CNT_W'(200);
        bus.start = 1;
        cyc();
        bus.start = 0;
        for (int k = 0; k < 1030; k++) begin
            bus.coin = ~bus.coin;
            cyc();
        end
        check_val("t3_count", bus.count, 255);
        check_val("t3_ovf",   bus.ovf,   1);
        bus.coin = 0; repeat (4) cyc();
        bus.win_len = WIN_W'(5); bus.start = 1;
        cyc();
        bus.start = 0;
        check_val("t3_clr_count", bus.count, 0);
        check_val("t3_clr_ovf",   bus.ovf,   0);
        repeat (8) cyc();

        // Abort mid-window, restart ignored in RUN, START+ABORT in IDLE
        bus.win_len = WIN_W'(30); bus.thresh = CNT_W'(1);
        bus.start = 1; bus.coin = 1; t = cyc_n; d0 = done_cnt;
        cyc();
        bus.start = 0; bus.coin = 0; cyc();
        bus.coin = 1; bus.start = 1; cyc();
        bus.coin = 0; bus.start = 0; cyc(); cyc();
        bus.abort = 1; cyc();
        bus.abort = 0;
        check_val("t4_busy_at6", bus.busy, 0);
        repeat (10) cyc();
        check_val("t4_no_done", done_cnt - d0, 0);
        check_val("t4_count",   bus.count, 2);
        check_val("t4_alarm",   bus.alarm, 0);
        bus.start = 1; bus.abort = 1; cyc();
        bus.start = 0; bus.abort = 0;
        check_val("t4_sa_busy", bus.busy, 0);
        cyc();
        check_val("t4_sa_busy2", bus.busy, 0);

        // Zero-length window, edge in the only RUN cycle, START in FIN ignored
        bus.win_len = '0; bus.thresh = CNT_W'(1);
        bus.coin = 1; cyc();
        bus.start = 1; bus.coin = 0; t = cyc_n;
        cyc();
        bus.start = 0; cyc();
        check_val("t5_done",  bus.done,  1);
        check_val("t5_count", bus.count, 1);
        check_val("t5_alarm", bus.alarm, 1);
        bus.start = 1; cyc();
        check_val("t5_fin_ignored", bus.busy, 0);
        cyc();
        check_val("t5_accept", bus.busy, 1);
        bus.start = 0; repeat (4) cyc();

        // Reset in the middle of a window with COIN high at release
        bus.win_len = WIN_W'(20); bus.thresh = '0;
        bus.start = 1; cyc();
        bus.start = 0; repeat (3) cyc();
        async_reset_check("t6_rst");
        bus.coin = 1; repeat (2) cyc();
        rst_n = 1'b1; d0 = done_cnt;
        repeat (6) cyc();
        check_val("t6_count", bus.count, 0);
        check_val("t6_busy",  bus.busy,  0);
        check_val("t6_done",  done_cnt - d0, 0);
        bus.coin = 0; repeat (4) cyc();

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            bus.start = ($urandom_range(0, 7) == 0);
            bus.abort = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 2) == 0) bus.coin = 1'($urandom_range(0, 1));
            bus.win_len = ($urandom_range(0, 3) == 0) ? WIN_W'($urandom_range(0, 3))
                                                      : WIN_W'($urandom_range(0, 40));
            bus.thresh = CNT_W'($urandom_range(0, 12));
            if ($urandom_range(0, 599) == 0) begin
                async_reset_check("rnd_rst");
                cyc();
                rst_n = 1'b1;
            end
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
